// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/response bundle between the execute stage and the HI/LO mul/div unit
interface hilo_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_src1;
  logic [DATA_W-1:0] req_src2;
  logic              flush;
  logic              busy;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_result;
  modport master (
    output req_valid, req_op, req_src1, req_src2, flush,
    input  req_ready, busy, resp_valid, resp_result
  );
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush,
    output req_ready, busy, resp_valid, resp_result
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO multiply/divide unit with pipelined multiplier and radix-2 restoring divider
// Ports: clk, reset (sync, active-high), bus (slave: req_valid/req_ready/req_op/req_src1/req_src2/flush/busy/resp_valid/resp_result)
// Build option: define HILO_MADD_EN to implement MADD/MADDU/MSUB/MSUBU; otherwise they decode as NOP
module hilo_muldiv_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input logic          clk,
  input logic          reset,
  hilo_muldiv_if.slave bus
);
  localparam int P  = 2 * DATA_W;
  localparam int CW = 7;
`ifdef HILO_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, MULS, DIVS, FIX, RESP} state_t;
  state_t            state, nxt;
  logic [3:0]        op;
  logic [DATA_W-1:0] a, b, hi, lo, quo, rem, dvs, res;
  logic [CW-1:0]     cnt;
  logic [P-1:0]      pipe [MUL_LAT];
  logic [P-1:0]      xa, xb, prod, acc;
  logic [DATA_W:0]   sh;
  logic              accept, ge, sdiv, smul, mul_op, div_op, mul_req, div_req;

  function automatic logic is_mul(input logic [3:0] o);
    return (o inside {4'd5, 4'd6, 4'd7}) || (MADD_EN && (o inside {[4'd10:4'd13]}));
  endfunction

  assign accept  = bus.req_valid && state == IDLE && !bus.flush;
  assign mul_req = is_mul(bus.req_op);
  assign div_req = bus.req_op inside {4'd8, 4'd9};
  assign mul_op  = is_mul(op);
  assign div_op  = op inside {4'd8, 4'd9};
  assign sdiv    = op == 4'd8;
  assign smul    = op inside {4'd5, 4'd7, 4'd10, 4'd12};
  // sign/zero extension to 2*DATA_W makes one unsigned multiply serve both signednesses
  assign xa      = smul ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign xb      = smul ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
  assign prod    = pipe[MUL_LAT-1];
  assign dvs     = sdiv && b[DATA_W-1] ? -b : b;
  assign sh      = {rem, quo[DATA_W-1]};
  assign ge      = sh >= {1'b0, dvs};
`ifdef HILO_MADD_EN
  assign acc = (op inside {4'd12, 4'd13}) ? {hi, lo} - prod :
               (op inside {4'd10, 4'd11}) ? {hi, lo} + prod : prod;
`else
  assign acc = prod;
`endif

  always_ff @(posedge clk)
    state <= reset || bus.flush ? IDLE : nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !accept ? IDLE : mul_req ? MULS : div_req ? DIVS : RESP;
      MULS:    nxt = cnt == CW'(MUL_LAT - 1) ? RESP : MULS;
      DIVS:    nxt = cnt == CW'(DATA_W - 1) ? FIX : DIVS;
      FIX:     nxt = RESP;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    res = op == 4'd3 ? hi :
          op == 4'd4 ? lo :
          (op inside {4'd1, 4'd2}) ? a :
          mul_op ? acc[DATA_W-1:0] :
          div_op ? quo : '0;
    bus.req_ready   = state == IDLE;
    bus.busy        = state != IDLE;
    bus.resp_valid  = state == RESP && !bus.flush;
    bus.resp_result = state == RESP ? res : '0;
  end

  always_ff @(posedge clk)
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == RESP && !bus.flush) begin
      if (op == 4'd1) hi <= a;
      if (op == 4'd2) lo <= a;
      if (mul_op && op != 4'd7) {hi, lo} <= acc;
      if (div_op) {hi, lo} <= {rem, quo};
    end

  // quo doubles as the dividend shift register; quotient bits enter at the bottom
  always_ff @(posedge clk)
    if (reset) begin
      op  <= '0;
      a   <= '0;
      b   <= '0;
      cnt <= '0;
      quo <= '0;
      rem <= '0;
    end else if (accept) begin
      op  <= bus.req_op;
      a   <= bus.req_src1;
      b   <= bus.req_src2;
      cnt <= '0;
      quo <= bus.req_op == 4'd8 && bus.req_src1[DATA_W-1] ? -bus.req_src1 : bus.req_src1;
      rem <= '0;
    end else if (state == MULS) begin
      cnt <= cnt + 1'b1;
    end else if (state == DIVS) begin
      cnt <= cnt + 1'b1;
      rem <= ge ? DATA_W'(sh - {1'b0, dvs}) : sh[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], ge};
    end else if (state == FIX) begin
      quo <= b == '0 ? '1 : sdiv && (a[DATA_W-1] ^ b[DATA_W-1]) ? -quo : quo;
      rem <= b == '0 ? a : sdiv && a[DATA_W-1] ? -rem : rem;
    end

  always_ff @(posedge clk) begin
    pipe[0] <= xa * xb;
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: self-checking bench for hilo_muldiv_unit against a plain-arithmetic HI/LO model
module tb_hilo_muldiv_unit;
  localparam int W = 32;
  localparam int MUL_LAT = 3;
`ifdef HILO_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = 0;
  logic [W-1:0] m_lo = 0;

  hilo_muldiv_if #(.DATA_W(W)) bus();
  hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic model(input logic [3:0] op, input logic [W-1:0] s1, s2, output logic [W-1:0] r, output int lat);
    logic [63:0] p, hl;
    int sa, sb;
    hl = {m_hi, m_lo};
    sa = s1;
    sb = s2;
    p = (op inside {5, 7, 10, 12}) ? 64'(longint'(sa) * longint'(sb)) : {32'b0, s1} * {32'b0, s2};
    r = 0;
    lat = 1;
    case (op)
      1: begin m_hi = s1; r = s1; end
      2: begin m_lo = s1; r = s1; end
      3: r = m_hi;
      4: r = m_lo;
      5, 6: begin {m_hi, m_lo} = p; r = p[31:0]; lat = MUL_LAT + 1; end
      7: begin r = p[31:0]; lat = MUL_LAT + 1; end
      8, 9: begin
        lat = W + 2;
        if (s2 == 0) begin m_lo = '1; m_hi = s1; end
        else if (op == 9) begin m_lo = s1 / s2; m_hi = s1 % s2; end
        else if (s1 == 32'h8000_0000 && s2 == 32'hFFFF_FFFF) begin m_lo = s1; m_hi = 0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
        r = m_lo;
      end
      10, 11, 12, 13: if (MADD) begin
        hl = op < 12 ? hl + p : hl - p;
        {m_hi, m_lo} = hl;
        r = hl[31:0];
        lat = MUL_LAT + 1;
      end
      default: r = 0;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] s1, s2, output logic [W-1:0] res, output int lat);
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_op = op;
    bus.req_src1 = s1;
    bus.req_src2 = s2;
    @(posedge clk);
    #1 bus.req_valid = 0;
    lat = 0;
    res = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i;
        res = bus.resp_result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [W-1:0] r;
    int l;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1 || bus.busy !== 0 || bus.resp_valid !== 0 || bus.resp_result !== 0) begin
      errors++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b result=%h, want 1 0 0 0",
               bus.req_ready, bus.busy, bus.resp_valid, bus.resp_result);
    end
    reset = 0;
    for (int k = 3; k <= 4; k++) begin
      do_op(4'(k), 0, 0, r, l);
      checks++;
      if (r !== 0 || l !== 1) begin
        errors++;
        $display("FAIL reset_hilo op%0d: got %h lat %0d, want 0 lat 1", k, r, l);
      end
    end
  endtask

  task automatic run_table(input string name, input logic [3:0] ops[], input logic [W-1:0] a[], input logic [W-1:0] b[]);
    logic [W-1:0] r, er;
    int l, el;
    foreach (ops[i]) begin
      model(ops[i], a[i], b[i], er, el);
      do_op(ops[i], a[i], b[i], r, l);
      checks++;
      if (r !== er || l !== el) begin
        errors++;
        $display("FAIL %s[%0d] op%0d %h,%h: got %h lat %0d, want %h lat %0d", name, i, ops[i], a[i], b[i], r, l, er, el);
      end
    end
  endtask

  task automatic test_mt_mf;
    run_table("mt_mf", '{4'd1, 4'd3, 4'd2, 4'd4, 4'd0, 4'd15},
              '{32'h1234_5678, 0, 32'hCAFE_0001, 0, 32'h55, 32'h66}, '{0, 0, 0, 0, 0, 0});
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 0 || bus.req_ready !== 1) begin
      errors++;
      $display("FAIL resp_pulse: valid=%b ready=%b after response, want 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_mul;
    run_table("mul", '{4'd5, 4'd3, 4'd4, 4'd7, 4'd3, 4'd4, 4'd6, 4'd3, 4'd4},
              '{32'hFFFF_FFFE, 0, 0, 7, 0, 0, 32'hFFFF_FFFF, 0, 0},
              '{3, 0, 0, 6, 0, 0, 32'hFFFF_FFFF, 0, 0});
  endtask

  task automatic test_div;
    run_table("div", '{4'd8, 4'd3, 4'd4, 4'd9, 4'd3, 4'd4, 4'd8, 4'd3, 4'd8, 4'd3, 4'd9, 4'd3},
              '{32'hFFFF_FFF9, 0, 0, 100, 0, 0, 32'h8000_0000, 0, 32'hFFFF_FF00, 0, 32'hFFFF_FFFF, 0},
              '{2, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 7, 0});
  endtask

  task automatic test_madd;
    run_table("madd", '{4'd1, 4'd2, 4'd11, 4'd3, 4'd4, 4'd12, 4'd3, 4'd4, 4'd10, 4'd13, 4'd3, 4'd4},
              '{0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 0, 32'hFFFF_0000, 32'h8000_0000, 0, 0},
              '{0, 0, 1, 0, 0, 1, 0, 0, 32'h0001_2345, 32'hFFFF_FFFF, 0, 0});
  endtask

  task automatic test_random;
    logic [W-1:0] r, er, s1, s2;
    logic [3:0] op;
    int l, el;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      s1 = $urandom;
      s2 = $urandom_range(0, 4) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 9) == 0) begin s1 = 32'h8000_0000; s2 = 32'hFFFF_FFFF; end
      model(op, s1, s2, er, el);
      do_op(op, s1, s2, r, l);
      checks++;
      if (r !== er || l !== el) begin
        errors++;
        $display("FAIL random[%0d] op%0d %h,%h: got %h lat %0d, want %h lat %0d", i, op, s1, s2, r, l, er, el);
      end
    end
    run_table("random_hilo", '{4'd3, 4'd4}, '{0, 0}, '{0, 0});
  endtask

  task automatic test_flush;
    bit seen;
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_op = 8;
    bus.req_src1 = 1000;
    bus.req_src2 = 7;
    @(posedge clk);
    #1 bus.req_valid = 0;
    repeat (9) @(negedge clk);
    bus.flush = 1;
    @(posedge clk);
    #1 bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1) begin
      errors++;
      $display("FAIL flush_div_ready: ready=%b, want 1", bus.req_ready);
    end
    seen = bus.resp_valid;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.resp_valid;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_div_resp: resp_valid seen=%b, want 0", seen);
    end
    run_table("flush_div_hilo", '{4'd3, 4'd4}, '{0, 0}, '{0, 0});
    @(negedge clk);
    bus.req_valid = 1;
    bus.flush = 1;
    bus.req_op = 1;
    bus.req_src1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.req_valid = 0;
    bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1 || bus.resp_valid !== 0) begin
      errors++;
      $display("FAIL flush_idle_accept: ready=%b valid=%b, want 1 0", bus.req_ready, bus.resp_valid);
    end
    run_table("flush_idle_hilo", '{4'd3}, '{0}, '{0});
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_op = 2;
    bus.req_src1 = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    bus.flush = 1;
    #1;
    checks++;
    if (bus.req_ready !== 0 || bus.resp_valid !== 0) begin
      errors++;
      $display("FAIL flush_resp: ready=%b valid=%b in flushed RESP, want 0 0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk);
    #1 bus.flush = 0;
    run_table("flush_resp_hilo", '{4'd4}, '{0}, '{0});
  endtask

  task automatic test_reset_mid;
    run_table("pre_reset", '{4'd1, 4'd2}, '{32'h55AA_55AA, 32'h1357_9BDF}, '{0, 0});
    @(negedge clk);
    bus.req_valid = 1;
    bus.req_op = 5;
    bus.req_src1 = 12345;
    bus.req_src2 = 6789;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    m_hi = 0;
    m_lo = 0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1 || bus.resp_valid !== 0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b valid=%b, want 1 0", bus.req_ready, bus.resp_valid);
    end
    run_table("reset_mid_hilo", '{4'd3, 4'd4}, '{0, 0}, '{0, 0});
  endtask

  initial begin
    bus.req_valid = 0;
    bus.req_op = 0;
    bus.req_src1 = 0;
    bus.req_src2 = 0;
    bus.flush = 0;
    repeat (2) @(posedge clk);
    test_reset;
    test_mt_mf;
    test_mul;
    test_div;
    test_madd;
    test_random;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
